// File: rtl/imm_pkg.sv
// Shared immediate-format codes and sign-extension helper for the decode stage.
package imm_pkg;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_I2   = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;
  localparam logic [2:0] IMM_SH   = 3'b110;
  localparam logic [2:0] IMM_JALR = 3'b111;

  // Sign-extend the low 'width' bits of val to 64 bits; callers truncate to XLEN.
  function automatic logic [63:0] sext(input logic [63:0] val, input int unsigned width);
    logic signed [63:0] t;
    t = signed'(val << (64 - width));
    return t >>> (64 - width);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instruction word + format code -> XLEN immediate.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BJ_SHIFT = 1
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immset,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [63:0] imm64;
  logic        unused_bits;

  // Select and extend the immediate field for the requested format.
  always_comb begin
    imm64 = '0;
    err   = 1'b0;
    case (immset)
      IMM_S:  imm64 = sext({52'b0, instr[31:25], instr[11:7]}, 12);
      IMM_B: begin
        if (BJ_SHIFT != 0)
          imm64 = sext({51'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13);
        else
          imm64 = sext({52'b0, instr[31], instr[7], instr[30:25], instr[11:8]}, 12);
      end
      IMM_J: begin
        if (BJ_SHIFT != 0)
          imm64 = sext({43'b0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21);
        else
          imm64 = sext({44'b0, instr[31], instr[19:12], instr[20], instr[30:21]}, 20);
      end
      IMM_U:  imm64 = sext({32'b0, instr[31:12], 12'b0}, 32);
      IMM_SH: begin
        if (XLEN == 64) begin
          imm64 = {58'b0, instr[25:20]};
        end else begin
          // A 6-bit shift amount is illegal on a 32-bit datapath.
          imm64 = {59'b0, instr[24:20]};
          err   = instr[25];
        end
      end
      default: imm64 = sext({52'b0, instr[31:20]}, 12);
    endcase
  end

  // Opcode bits and the upper half on 32-bit builds carry no immediate information.
  assign unused_bits = ^{instr[6:0], imm64};
  assign imm         = imm64[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready stream, 2-entry skid buffer and flush.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 32,
  parameter int BJ_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immset,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } beat_t;

  logic [XLEN-1:0] ext_imm;
  logic            ext_err;
  beat_t           in_beat;
  beat_t           main_q, main_d, skid_q, skid_d;
  logic            main_vld_q, main_vld_d;
  logic            skid_vld_q, skid_vld_d;
  logic            in_ready_q, in_ready_d;
  logic            accept, main_free;

  imm_extract #(
    .XLEN    (XLEN),
    .BJ_SHIFT(BJ_SHIFT)
  ) u_extract (
    .instr (in_instr),
    .immset(in_immset),
    .imm   (ext_imm),
    .err   (ext_err)
  );

  assign in_beat   = '{imm: ext_imm, tag: in_tag, err: ext_err};
  assign accept    = in_valid & in_ready_q;
  assign main_free = ~main_vld_q | out_ready;

  // Next-state for the main/skid pair; skid always refills main before new input.
  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_free) begin
      if (skid_vld_q) begin
        // in_ready was low, so no new beat can arrive in this cycle.
        main_vld_d = 1'b1;
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_vld_d = 1'b1;
        main_d     = in_beat;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_d     = in_beat;
    end
    in_ready_d = ~skid_vld_d;
  end

  // State registers; reset clears the data path too so outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_imm   = main_q.imm;
  assign out_tag   = main_q.tag;
  assign out_err   = main_q.err;

endmodule
